stg_if: RTL and testbench
=========================

Name: stg_if

Overview:
- Instruction-fetch stage. Produces the pc/instr pair consumed by the decode stage.
- Drives a synchronous instruction-memory read port with fixed 1-cycle read latency.
- Honours the same stall signal the decode stage sees; a taken branch redirects fetch.
- Injects bubbles (pc 0, NOP) wherever no valid instruction is available.

Parameters:
- RESET_PC, 0: first fetch address after reset.
- NOP_INSTR, 0: instruction word emitted as a bubble; opcode 0 decodes as no-op, matching the decode stage's flush value.

Ports:
- iw_clk  input  1  clock; all state updates on rising edge
- iw_rst  input  1  reset, asynchronous, active-high
- ow_imem_en  output  1  read request this cycle
- ow_imem_addr  output  `SIZE_ADDR  word address of the request
- iw_imem_data  input  `SIZE_DATA  read data, valid the cycle after a request
- iw_branch_taken  input  1  redirect fetch this cycle
- iw_branch_pc  input  `SIZE_ADDR  redirect target
- iw_stall  input  1  downstream stall; hold outputs
- ow_pc  output  `SIZE_ADDR  registered pc to decode
- ow_instr  output  `SIZE_DATA  registered instruction to decode

Behaviour:
- Internal state:
  - r_fetch_pc: next address to request.
  - r_pend_v / r_pend_pc: a request is in flight; its data arrives this cycle.
  - r_skid_v / r_skid_pc / r_skid_instr: data captured while stalled.
- Reset (async, any time, including mid-operation): r_fetch_pc=RESET_PC; r_pend_v=0; r_skid_v=0; ow_pc=0; ow_instr=NOP_INSTR. Any in-flight read is discarded.
- Combinational request, in priority order:
  - iw_branch_taken: ow_imem_en=1, ow_imem_addr=iw_branch_pc.
  - else iw_stall: ow_imem_en=0, ow_imem_addr=r_fetch_pc.
  - else: ow_imem_en=1, ow_imem_addr=r_fetch_pc.
- Per-edge update, in priority order:
  - REDIRECT (iw_branch_taken, overrides stall):
    - r_pend_v=1, r_pend_pc=iw_branch_pc, r_fetch_pc=iw_branch_pc+1.
    - r_skid_v=0.
    - Outputs <= bubble (pc 0, NOP_INSTR).
    - Any returning data is dropped.
  - HOLD (iw_stall):
    - Outputs, r_fetch_pc and r_skid_* unchanged, except: if r_pend_v, then r_skid_v=1, r_skid_pc=r_pend_pc, r_skid_instr=iw_imem_data, and r_pend_v=0.
    - No new request, so at most one instruction ever needs buffering.
  - RUN (neither):
    - Outputs <= skid contents if r_skid_v; else <= (r_pend_pc, iw_imem_data) if r_pend_v; else bubble.
    - r_skid_v=0.
    - New request: r_pend_v=1, r_pend_pc=r_fetch_pc, r_fetch_pc=r_fetch_pc+1.
    - r_skid_v and r_pend_v are never both 1 entering RUN.
- Latency:
  - Address requested at edge N appears on ow_pc/ow_instr after edge N+1, absent stall.
  - Steady-state throughput: one instruction per cycle.
  - Redirect costs exactly one bubble at the output.
- Arithmetic: pc increment is modulo 2^`SIZE_ADDR; fetch from all-ones wraps to 0 with no special handling.
- Ordering: instructions leave in strictly increasing pc order between redirects, with no duplicates and no drops across any stall length.
- Stall on the cycle after reset: no request is issued; bubbles hold.

Test Plan:
- Reset release, RESET_PC=0, mem[i]=0x100+i, no stall:
  - ow_imem_addr 0,1,2,... one per cycle.
  - After edge 2, ow_pc=0 / ow_instr=0x100, then pc 1 / 0x101 each subsequent cycle.
- Stall for 3 cycles while the request for pc 5 is in flight:
  - ow_pc=4 held for 3 cycles; ow_imem_en=0 during the stall.
  - On release, pc 5/0x105 then 6/0x106, contiguous, no repeat or gap.
- iw_branch_taken with iw_branch_pc=0x20 while pc 7 is in flight:
  - Next output is bubble (pc 0, NOP_INSTR), then pc 0x20 / mem[0x20], then 0x21.
  - pc 7 is never emitted.
- Branch and stall asserted in the same cycle:
  - Redirect wins; output becomes a bubble and skid is cleared.
  - After the stall drops, the first instruction out is mem[0x20].
- Wrap: RESET_PC=all-ones.
  - Outputs pc all-ones then pc 0, with instr mem[max] then mem[0].
- Async reset asserted mid-stream with skid full:
  - Immediately (no clock edge) ow_pc=0, ow_instr=NOP_INSTR.
  - After release, the sequence restarts at RESET_PC.

Source files
------------

// File: rtl/stg_if_if.sv
// Instruction-memory read port between the fetch stage and a synchronous memory.
// The fetch stage drives the request; read data comes back one cycle later.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

interface stg_if_if;
  logic                  en;
  logic [`SIZE_ADDR-1:0] addr;
  logic [`SIZE_DATA-1:0] data;

  modport master (output en, output addr, input data);
  modport slave  (input en, input addr, output data);
endinterface

// File: rtl/stg_if.sv
// Instruction-fetch stage: issues one read per cycle, buffers one word in a skid
// register under stall, and emits bubbles where no valid instruction exists.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module stg_if #(
  parameter logic [`SIZE_ADDR-1:0] RESET_PC  = '0,
  parameter logic [`SIZE_DATA-1:0] NOP_INSTR = '0
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  stg_if_if.master              imem,
  input  logic                  iw_branch_taken,
  input  logic [`SIZE_ADDR-1:0] iw_branch_pc,
  input  logic                  iw_stall,
  output logic [`SIZE_ADDR-1:0] ow_pc,
  output logic [`SIZE_DATA-1:0] ow_instr
);

  logic [`SIZE_ADDR-1:0] fetch_pc_q, fetch_pc_d;
  logic                  pend_v_q, pend_v_d;
  logic [`SIZE_ADDR-1:0] pend_pc_q, pend_pc_d;
  logic                  skid_v_q, skid_v_d;
  logic [`SIZE_ADDR-1:0] skid_pc_q, skid_pc_d;
  logic [`SIZE_DATA-1:0] skid_instr_q, skid_instr_d;
  logic [`SIZE_ADDR-1:0] pc_q, pc_d;
  logic [`SIZE_DATA-1:0] instr_q, instr_d;

  always_comb begin
    imem.en   = 1'b1;
    imem.addr = fetch_pc_q;
    if (iw_branch_taken) begin
      imem.addr = iw_branch_pc;
    end else if (iw_stall) begin
      imem.en = 1'b0;
    end
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pend_v_d     = pend_v_q;
    pend_pc_d    = pend_pc_q;
    skid_v_d     = skid_v_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    pc_d         = pc_q;
    instr_d      = instr_q;

    if (iw_branch_taken) begin
      // Redirect wins over stall; in-flight and skid data belong to the old path.
      pend_v_d   = 1'b1;
      pend_pc_d  = iw_branch_pc;
      fetch_pc_d = iw_branch_pc + 1'b1;
      skid_v_d   = 1'b0;
      pc_d       = '0;
      instr_d    = NOP_INSTR;
    end else if (iw_stall) begin
      if (pend_v_q) begin
        skid_v_d     = 1'b1;
        skid_pc_d    = pend_pc_q;
        skid_instr_d = imem.data;
        pend_v_d     = 1'b0;
      end
    end else begin
      if (skid_v_q) begin
        pc_d    = skid_pc_q;
        instr_d = skid_instr_q;
      end else if (pend_v_q) begin
        pc_d    = pend_pc_q;
        instr_d = imem.data;
      end else begin
        pc_d    = '0;
        instr_d = NOP_INSTR;
      end
      skid_v_d   = 1'b0;
      pend_v_d   = 1'b1;
      pend_pc_d  = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 1'b1;
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      fetch_pc_q   <= RESET_PC;
      pend_v_q     <= 1'b0;
      pend_pc_q    <= '0;
      skid_v_q     <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      pc_q         <= '0;
      instr_q      <= NOP_INSTR;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pend_v_q     <= pend_v_d;
      pend_pc_q    <= pend_pc_d;
      skid_v_q     <= skid_v_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
    end
  end

  assign ow_pc    = pc_q;
  assign ow_instr = instr_q;

endmodule

// File: tb/tb_stg_if.sv
// Directed bench for stg_if: memory returns 0x100+addr one cycle after a request.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module tb_stg_if;
  logic                  clk;
  logic                  rst;
  logic                  branch_taken;
  logic [`SIZE_ADDR-1:0] branch_pc;
  logic                  stall;
  logic [`SIZE_ADDR-1:0] pc, pc_w;
  logic [`SIZE_DATA-1:0] instr, instr_w;
  int unsigned           n_tests;
  int unsigned           n_fail;

  stg_if_if imem ();
  stg_if_if imem_w ();

  stg_if #(.RESET_PC('0), .NOP_INSTR('0)) u_dut (
    .iw_clk          (clk),
    .iw_rst          (rst),
    .imem            (imem),
    .iw_branch_taken (branch_taken),
    .iw_branch_pc    (branch_pc),
    .iw_stall        (stall),
    .ow_pc           (pc),
    .ow_instr        (instr)
  );

  // Second instance starting at the top of the address space, never stalled.
  stg_if #(.RESET_PC('1), .NOP_INSTR('0)) u_dut_wrap (
    .iw_clk          (clk),
    .iw_rst          (rst),
    .imem            (imem_w),
    .iw_branch_taken (1'b0),
    .iw_branch_pc    ('0),
    .iw_stall        (1'b0),
    .ow_pc           (pc_w),
    .ow_instr        (instr_w)
  );

  always @(posedge clk) begin
    if (imem.en) imem.data <= 32'h100 + 32'(imem.addr);
    if (imem_w.en) imem_w.data <= 32'h100 + 32'(imem_w.addr);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] epc, input logic [31:0] einstr);
    check_eq({tag, "_pc"}, 32'(pc), epc);
    check_eq({tag, "_instr"}, instr, einstr);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    stall        = 1'b0;
    branch_taken = 1'b0;
    branch_pc    = '0;
    imem.data    = '0;
    imem_w.data  = '0;
    tick();
    tick();
    check_out("reset", 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("req0_en", 32'(imem.en), 32'h1);
    check_eq("req0_addr", 32'(imem.addr), 32'h0);

    tick();  // edge 1: first request issued, output still a bubble
    check_out("edge1", 32'h0, 32'h0);
    check_eq("req1_addr", 32'(imem.addr), 32'h1);
    tick();  // edge 2
    check_out("edge2", 32'h0, 32'h100);
    check_eq("wrap_max_pc", 32'(pc_w), 32'hFFFF);
    check_eq("wrap_max_instr", instr_w, 32'h100FF);
    tick();  // edge 3
    check_out("edge3", 32'h1, 32'h101);
    check_eq("wrap_zero_pc", 32'(pc_w), 32'h0);
    check_eq("wrap_zero_instr", instr_w, 32'h100);
    for (int k = 4; k <= 6; k++) begin
      tick();
      check_out("stream", 32'(k - 2), 32'h100 + 32'(k - 2));
    end

    // Stall three cycles with pc 5 in flight.
    stall = 1'b1;
    #1;
    check_eq("stall_en", 32'(imem.en), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out("stall_hold", 32'h4, 32'h104);
    end
    stall = 1'b0;
    tick();
    check_out("release5", 32'h5, 32'h105);
    tick();
    check_out("release6", 32'h6, 32'h106);

    // Branch while pc 7 is in flight.
    branch_taken = 1'b1;
    branch_pc    = 16'h20;
    #1;
    check_eq("br_en", 32'(imem.en), 32'h1);
    check_eq("br_addr", 32'(imem.addr), 32'h20);
    tick();
    branch_taken = 1'b0;
    check_out("br_bubble", 32'h0, 32'h0);
    tick();
    check_out("br_tgt", 32'h20, 32'h120);
    tick();
    check_out("br_tgt1", 32'h21, 32'h121);

    // Fill skid, then branch and stall together.
    stall = 1'b1;
    tick();
    check_out("skid_fill", 32'h21, 32'h121);
    branch_taken = 1'b1;
    branch_pc    = 16'h20;
    #1;
    check_eq("brst_en", 32'(imem.en), 32'h1);
    check_eq("brst_addr", 32'(imem.addr), 32'h20);
    tick();
    branch_taken = 1'b0;
    check_out("brst_bubble", 32'h0, 32'h0);
    tick();
    check_out("brst_hold", 32'h0, 32'h0);
    stall = 1'b0;
    tick();
    check_out("brst_first", 32'h20, 32'h120);
    tick();
    check_out("brst_next", 32'h21, 32'h121);

    // Async reset mid-stream with the skid holding pc 0x22.
    stall = 1'b1;
    tick();
    check_out("pre_rst", 32'h21, 32'h121);
    #2;
    rst = 1'b1;
    #1;
    check_out("async_rst", 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("rst_stall_en", 32'(imem.en), 32'h0);
    check_eq("rst_stall_addr", 32'(imem.addr), 32'h0);
    tick();
    check_out("rst_stall_b0", 32'h0, 32'h0);
    tick();
    check_out("rst_stall_b1", 32'h0, 32'h0);
    stall = 1'b0;
    tick();
    check_out("restart_b", 32'h0, 32'h0);
    tick();
    check_out("restart0", 32'h0, 32'h100);
    tick();
    check_out("restart1", 32'h1, 32'h101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
